// File: rtl/uart_pad_rx_if.sv
// Receive byte stream from uart_pad_rx to its consumer.
// First-word fall-through: data is the FIFO head while valid.
interface uart_pad_rx_if;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;

  modport master (
    output rx_data_o,
    output rx_valid_o,
    input  rx_ready_i
  );

  modport slave (
    input  rx_data_o,
    input  rx_valid_o,
    output rx_ready_i
  );
endinterface

// File: rtl/uart_pad_rx.sv
// 8N1 UART receiver, 16x oversampling, with receive FIFO
// and RTS flow control towards the pad.
module uart_pad_rx #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] divisor_i,
  uart_pad_rx_if.master    rx_bus,
  output logic             rts_n_o,
  output logic             frame_err_o,
  output logic             overrun_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] RTS_CNT  = (AW+1)'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             rx_meta;
  logic             rx_s;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] tick_cnt;
  logic [3:0]       smp_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             tick;
  logic             mid_tick;
  logic             end_tick;
  logic             stop_hit;
  logic             push_req;
  logic             push;
  logic             pop;
  logic             full;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  assign tick     = (state != IDLE) && (tick_cnt == div_q);
  assign mid_tick = tick && (smp_cnt == 4'd7);
  assign end_tick = tick && (smp_cnt == 4'd15);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!en_i) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:  if (!rx_s) state_nxt = START;
        START: if (mid_tick) state_nxt = rx_s ? IDLE : DATA;
        DATA:  if (end_tick && bit_cnt == 3'd7) state_nxt = STOP;
        STOP:  if (end_tick) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    stop_hit    = en_i && (state == STOP) && end_tick;
    push_req    = stop_hit && rx_s;
    frame_err_o = stop_hit && !rx_s;
    overrun_o   = push_req && full && !pop;
    push        = push_req && (!full || pop);
  end

  // Counters only run inside a frame; IDLE and disable park them at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= '0;
      tick_cnt <= '0;
      smp_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else if (!en_i || state == IDLE) begin
      tick_cnt <= '0;
      smp_cnt  <= '0;
      bit_cnt  <= '0;
      if (!en_i) shreg <= '0;
      if (en_i && !rx_s) div_q <= divisor_i;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + DIV_W'(1);
      if (tick) smp_cnt <= smp_cnt + 4'd1;
      if (state == START && mid_tick) smp_cnt <= '0;
      if (state == DATA && end_tick) begin
        shreg   <= {rx_s, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  assign full              = (count == FULL_CNT);
  assign rx_bus.rx_valid_o = (count != '0);
  assign rx_bus.rx_data_o  = mem[rd_ptr];
  assign pop = rx_bus.rx_valid_o && rx_bus.rx_ready_i;

  always_comb begin
    count_nxt = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + (AW+1)'(1);
      2'b01:   count_nxt = count - (AW+1)'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rts_n_o <= 1'b1;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count   <= count_nxt;
      rts_n_o <= (count_nxt >= RTS_CNT);
    end
  end

endmodule

// File: tb/tb_uart_pad_rx.sv
// Directed bench for uart_pad_rx: clean frames, glitch,
// framing error, FIFO overrun/RTS, reset and enable abort.
module tb_uart_pad_rx;

  logic        clk;
  logic        rst;
  logic        rx;
  logic        en;
  logic [15:0] divisor;
  logic        rts_n;
  logic        ferr;
  logic        ovr;

  uart_pad_rx_if bus ();

  uart_pad_rx #(
    .FIFO_DEPTH(4),
    .DIV_W     (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_i       (rx),
    .en_i       (en),
    .divisor_i  (divisor),
    .rx_bus     (bus),
    .rts_n_o    (rts_n),
    .frame_err_o(ferr),
    .overrun_o  (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         total;
  int         bad;
  int         cyc_n;
  int         start_cyc;
  int         vld_cyc;
  bit         vld_mark;
  int         ferr_n;
  int         ovr_n;
  logic [7:0] got_q [$];

  always @(posedge clk) cyc_n++;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rx_valid_o && bus.rx_ready_i) got_q.push_back(bus.rx_data_o);
      if (ferr) ferr_n++;
      if (ovr) ovr_n++;
      if (bus.rx_valid_o && !vld_mark) begin
        vld_mark = 1'b1;
        vld_cyc  = cyc_n;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop,
                           input int bc, input int new_div);
    start_cyc = cyc_n;
    rx = 1'b0;
    if (new_div >= 0) begin
      cyc(bc / 2);
      divisor = 16'(new_div);
      cyc(bc - bc / 2);
    end else begin
      cyc(bc);
    end
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cyc(bc);
    end
    rx = stop;
    cyc(bc);
    rx = 1'b1;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    cyc_n    = 0;
    ferr_n   = 0;
    ovr_n    = 0;
    vld_mark = 1'b0;
    rst      = 1'b1;
    rx       = 1'b1;
    en       = 1'b1;
    divisor  = 16'd0;
    bus.rx_ready_i = 1'b0;

    // Reset values
    cyc(3);
    chk("rst_valid", bus.rx_valid_o, 0);
    chk("rst_data", bus.rx_data_o, 8'h00);
    chk("rst_rts", rts_n, 1);
    chk("rst_ferr", ferr, 0);
    chk("rst_ovr", ovr, 0);
    rst = 1'b0;
    #1;
    chk("rts_hold", rts_n, 1);
    cyc(1);
    chk("rts_release", rts_n, 0);
    cyc(5);

    // Clean 0xA5 at 16 clk/bit, with latency
    bus.rx_ready_i = 1'b1;
    vld_mark = 1'b0;
    send_byte(8'hA5, 1'b1, 16, -1);
    cyc(10);
    chk("a5_cnt", got_q.size(), 1);
    if (got_q.size() > 0) chk("a5_data", got_q[0], 8'hA5);
    chk("a5_lat_ok", (vld_cyc - start_cyc >= 150) &&
                     (vld_cyc - start_cyc <= 158), 1);
    chk("a5_ferr", ferr_n, 0);
    chk("a5_ovr", ovr_n, 0);
    got_q.delete();

    // Start-bit glitch, then a frame with divisor changed mid-frame
    divisor = 16'd3;
    rx = 1'b0;
    cyc(20);
    rx = 1'b1;
    cyc(200);
    chk("gl_cnt", got_q.size(), 0);
    chk("gl_ferr", ferr_n, 0);
    chk("gl_valid", bus.rx_valid_o, 0);
    send_byte(8'h3C, 1'b1, 64, 0);
    cyc(10);
    chk("3c_cnt", got_q.size(), 1);
    if (got_q.size() > 0) chk("3c_data", got_q[0], 8'h3C);
    got_q.delete();
    divisor = 16'd0;
    cyc(20);

    // Bad stop bit
    send_byte(8'h3C, 1'b0, 16, -1);
    cyc(40);
    chk("fe_pulses", ferr_n, 1);
    chk("fe_cnt", got_q.size(), 0);
    chk("fe_valid", bus.rx_valid_o, 0);
    chk("fe_rts", rts_n, 0);
    chk("fe_ovr", ovr_n, 0);

    // Fill FIFO with back-to-back frames, overrun on 5th
    bus.rx_ready_i = 1'b0;
    send_byte(8'h01, 1'b1, 16, -1);
    chk("ff_rts1", rts_n, 0);
    send_byte(8'h02, 1'b1, 16, -1);
    chk("ff_rts2", rts_n, 0);
    send_byte(8'h03, 1'b1, 16, -1);
    chk("ff_rts3", rts_n, 1);
    send_byte(8'h04, 1'b1, 16, -1);
    chk("ff_rts4", rts_n, 1);
    send_byte(8'h05, 1'b1, 16, -1);
    cyc(10);
    chk("ff_ovr", ovr_n, 1);
    chk("ff_ferr", ferr_n, 1);
    chk("ff_head", bus.rx_data_o, 8'h01);
    chk("ff_valid", bus.rx_valid_o, 1);
    bus.rx_ready_i = 1'b1;
    cyc(1);
    chk("ff_rts_c3", rts_n, 1);
    cyc(1);
    chk("ff_rts_c2", rts_n, 0);
    cyc(6);
    chk("ff_popn", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      chk($sformatf("ff_pop%0d", i), got_q[i], 32'(i + 1));
    chk("ff_empty", bus.rx_valid_o, 0);
    got_q.delete();

    // Reset in the middle of DATA
    rx = 1'b0;
    cyc(16);
    rx = 1'b1;
    cyc(16);
    rx = 1'b0;
    cyc(16);
    rst = 1'b1;
    cyc(1);
    chk("mr_valid", bus.rx_valid_o, 0);
    chk("mr_data", bus.rx_data_o, 8'h00);
    chk("mr_rts", rts_n, 1);
    chk("mr_ferr", ferr, 0);
    chk("mr_ovr", ovr, 0);
    rx = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(40);
    chk("mr_cnt0", got_q.size(), 0);
    send_byte(8'h55, 1'b1, 16, -1);
    cyc(10);
    chk("55_cnt", got_q.size(), 1);
    if (got_q.size() > 0) chk("55_data", got_q[0], 8'h55);
    got_q.delete();

    // Enable drop mid-frame with one byte queued
    bus.rx_ready_i = 1'b0;
    send_byte(8'h77, 1'b1, 16, -1);
    cyc(10);
    rx = 1'b0;
    cyc(48);
    en = 1'b0;
    rx = 1'b1;
    cyc(20);
    en = 1'b1;
    cyc(200);
    chk("en_valid", bus.rx_valid_o, 1);
    chk("en_head", bus.rx_data_o, 8'h77);
    bus.rx_ready_i = 1'b1;
    cyc(4);
    chk("en_cnt", got_q.size(), 1);
    if (got_q.size() > 0) chk("en_data", got_q[0], 8'h77);
    chk("en_empty", bus.rx_valid_o, 0);
    send_byte(8'h0F, 1'b1, 16, -1);
    cyc(10);
    chk("0f_cnt", got_q.size(), 2);
    if (got_q.size() > 1) chk("0f_data", got_q[1], 8'h0F);
    chk("end_ferr", ferr_n, 1);
    chk("end_ovr", ovr_n, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_pad_rx.md
UART_PAD_RX -- requirements
Module: uart_pad_rx

Interface
- REQ-001: Parameter FIFO_DEPTH, default 4, sets the receive FIFO entry count; it SHALL be a power of two and at least 2.
- REQ-002: Parameter DIV_W, default 16, sets the width of divisor_i.
- REQ-003: clk  in  1  single clock; all state SHALL be clocked on its rising edge.
- REQ-004: rst  in  1  asynchronous, active-high reset.
- REQ-005: rx_i  in  1  serial data from the pad input (C output); asynchronous to clk; idles high.
- REQ-006: en_i  in  1  receiver enable.
- REQ-007: divisor_i  in  DIV_W  oversample tick period minus 1, in clk cycles.
- REQ-008: rx_data_o  out  8  FIFO head byte (first-word fall-through).
- REQ-009: rx_valid_o  out  1  FIFO not empty.
- REQ-010: rx_ready_i  in  1  consumer accepts the head byte.
- REQ-011: rts_n_o  out  1  flow control to the uart_rts pad; 0 means "send more".
- REQ-012: frame_err_o  out  1  one-cycle pulse on a bad stop bit.
- REQ-013: overrun_o  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

Function
- REQ-014: rx_i SHALL pass through a 2-flop synchronizer (reset value 1) before any use; below, "rx" means the synchronized value.
- REQ-015: Tick generator: the counter SHALL count 0..div_q and emit a one-cycle tick when it equals div_q, then return to 0. div_q is divisor_i latched on start detect.
- REQ-016: Frame format SHALL be 8N1, LSB first, with 16 ticks per bit.
- REQ-017: FSM states SHALL be IDLE, START, DATA and STOP.
- REQ-018: IDLE: when rx==0, go to START; latch divisor_i into div_q; clear the tick counter and the sample counter.
- REQ-019: START: on the 8th tick (mid-bit), if rx==0 go to DATA and clear the sample counter; otherwise treat it as a glitch and return to IDLE with no output.
- REQ-020: DATA: every 16th tick, shift rx into the shift register MSB-side (so the first bit received lands in bit 0); after 8 samples go to STOP.
- REQ-021: STOP: on the 16th tick, sample rx.
  - rx==1 and FIFO has space or a pop occurs this cycle: push the byte.
  - rx==1 and FIFO full with no pop: pulse overrun_o and drop the byte.
  - rx==0: pulse frame_err_o and discard the byte.
  - In all cases return to IDLE in the same cycle. Returning at mid-stop-bit allows back-to-back frames.
- REQ-022: en_i==0 SHALL force the FSM to IDLE synchronously and discard any partial byte. FIFO contents, rx_valid_o and pops SHALL be unaffected.
- REQ-023: The FIFO SHALL be circular, with pointers wrapping modulo FIFO_DEPTH and an occupancy count of width log2(FIFO_DEPTH)+1.
- REQ-024: A pop SHALL occur when rx_valid_o && rx_ready_i.
- REQ-025: Simultaneous push and pop SHALL leave the count unchanged, including when the FIFO is full.
- REQ-026: A pop when empty SHALL have no effect.
- REQ-027: rx_data_o SHALL equal the head entry whenever rx_valid_o==1; its value is don't-care when empty.
- REQ-028: Latency: a pushed byte SHALL appear on rx_valid_o/rx_data_o on the cycle after the stop-bit sample.
- REQ-029: rts_n_o SHALL be registered and equal 1 exactly when next-state count >= FIFO_DEPTH-1, otherwise 0.
- REQ-030: divisor_i changes mid-frame SHALL NOT affect the current frame; only div_q is used.

Reset
- REQ-031: While rst==1, the block SHALL hold these values:
  - FSM=IDLE; synchronizer=1; all counters=0.
  - FIFO empty; rx_valid_o=0; rx_data_o=0.
  - frame_err_o=0; overrun_o=0; rts_n_o=1.
- REQ-032: On the first clk edge after rst deasserts, rts_n_o SHALL go to 0.
- REQ-033: Reset asserted mid-frame SHALL abort the frame with no push or pulse; the next complete frame SHALL be received correctly.

Verification
- REQ-034: divisor_i=0 (16 clk/bit), en_i=1, rx_ready_i=1, send 0xA5 -> single rx_valid_o pulse with rx_data_o=0xA5 about 154 clk after the falling start edge; no error pulses.
- REQ-035: divisor_i=3, rx_i low for 20 clk then high -> no rx_valid_o, no error pulses, FSM back in IDLE; a following 0x3C frame is received as 0x3C.
- REQ-036: divisor_i=0, send 0x3C with stop bit 0 -> frame_err_o high for exactly 1 cycle; FIFO count unchanged.
- REQ-037: FIFO_DEPTH=4, rx_ready_i=0, send 0x01..0x05 back-to-back:
  - rts_n_o goes to 1 after byte 0x03 is pushed.
  - Byte 0x05 produces one overrun_o pulse.
  - Raising rx_ready_i then pops 0x01, 0x02, 0x03, 0x04 in order, and rts_n_o returns to 0 once count<=2.
- REQ-038: Assert rst during DATA of 0x55 -> all outputs at their reset values. Deassert, then send 0x55 -> rx_data_o=0x55.
- REQ-039: Drop en_i during DATA of 0xF0 with one byte already queued -> the queued byte is still delivered; no push for 0xF0. Re-raise en_i and send 0x0F -> 0x0F is received.
